// File: rtl/sprite_line_scheduler.sv
// Sprite descriptor table and once-per-scanline slot scheduler.
// Optional hit counter output enabled by defining SPRITE_SCHED_HIT_COUNT_EN.
module sprite_line_scheduler #(
  parameter int NUM_ENTRIES = 16,
  parameter int NUM_SLOTS   = 4
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_ENTRIES)-1:0] wr_addr,
  input  logic [31:0]                    wr_data,
  input  logic                           line_start,
  input  logic [9:0]                     next_line,
  output logic [32*NUM_SLOTS-1:0]        slot_val,
  output logic [NUM_SLOTS-1:0]           slot_valid,
  output logic                           busy,
`ifdef SPRITE_SCHED_HIT_COUNT_EN
  output logic [6:0]                     hit_count,
`endif
  output logic                           overflow
);

  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int CW = $clog2(NUM_SLOTS + 1);

  localparam logic [5:0] ID_SMALL = 6'b000010;
  localparam logic [5:0] ID_LARGE = 6'b011010;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  state_t          state_q;
  logic [31:0]     table_q [NUM_ENTRIES];
  logic [31:0]     stage_q [NUM_SLOTS];
  logic [31:0]     slot_q  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] stage_v_q;
  logic [NUM_SLOTS-1:0] valid_q;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   cnt_q;
  logic [9:0]      line_q;
  logic            ovf_line_q;
  logic            ovf_q;
  logic            busy_q;
`ifdef SPRITE_SCHED_HIT_COUNT_EN
  logic [6:0]      hits_line_q;
  logic [6:0]      hits_q;
`endif

  logic [31:0] cur;
  logic [4:0]  height;
  logic [9:0]  top;
  logic [10:0] bot;
  logic        hit;

  // Evaluate the entry under the scan pointer against the latched line
  always_comb begin
    cur    = table_q[idx_q];
    top    = cur[13:4];
    height = 5'd0;
    unique case (1'b1)
      (cur[31:26] == ID_SMALL): height = 5'd9;
      (cur[31:26] == ID_LARGE): height = 5'd20;
      default:                  height = 5'd0;
    endcase
    bot = {1'b0, top} + {6'd0, height};
    hit = (height != 5'd0) && (line_q >= top) &&
          ({1'b0, line_q} < bot);
  end

  // Descriptor table: writes land immediately, even mid-scan
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) table_q[i] <= '0;
    end else if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  // Scan FSM: stage hits, then commit all slots in a single edge
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      line_q     <= '0;
      ovf_line_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      stage_v_q  <= '0;
      valid_q    <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        stage_q[k] <= '0;
        slot_q[k]  <= '0;
      end
`ifdef SPRITE_SCHED_HIT_COUNT_EN
      hits_line_q <= '0;
      hits_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (line_start) begin
            state_q    <= SCAN;
            busy_q     <= 1'b1;
            line_q     <= next_line;
            idx_q      <= '0;
            cnt_q      <= '0;
            ovf_line_q <= 1'b0;
            stage_v_q  <= '0;
            for (int k = 0; k < NUM_SLOTS; k++) stage_q[k] <= '0;
`ifdef SPRITE_SCHED_HIT_COUNT_EN
            hits_line_q <= '0;
`endif
          end
        end
        SCAN: begin
          if (hit) begin
            if (cnt_q < CW'(NUM_SLOTS)) begin
              for (int k = 0; k < NUM_SLOTS; k++) begin
                if (cnt_q == CW'(k)) begin
                  stage_q[k]   <= cur;
                  stage_v_q[k] <= 1'b1;
                end
              end
              cnt_q <= cnt_q + CW'(1);
            end else begin
              ovf_line_q <= 1'b1;
            end
`ifdef SPRITE_SCHED_HIT_COUNT_EN
            if (hits_line_q != 7'd127) hits_line_q <= hits_line_q + 7'd1;
`endif
          end
          idx_q <= idx_q + IW'(1);
          if (idx_q == IW'(NUM_ENTRIES - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          for (int k = 0; k < NUM_SLOTS; k++) slot_q[k] <= stage_q[k];
          valid_q <= stage_v_q;
          ovf_q   <= ovf_line_q;
`ifdef SPRITE_SCHED_HIT_COUNT_EN
          hits_q  <= hits_line_q;
`endif
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    assign slot_val[32*k +: 32] = slot_q[k];
  end

  assign slot_valid = valid_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
`ifdef SPRITE_SCHED_HIT_COUNT_EN
  assign hit_count  = hits_q;
`endif

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed scoreboard bench for sprite_line_scheduler.
// Expected commits are queued at line start and checked at commit.
module tb_sprite_line_scheduler;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic         line_start = 1'b0;
  logic [9:0]   next_line = '0;
  logic [127:0] slot_val;
  logic [3:0]   slot_valid;
  logic         busy;
  logic         overflow;
`ifdef SPRITE_SCHED_HIT_COUNT_EN
  logic [6:0]   hit_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] val;
    logic [3:0]   v;
    logic         ovf;
    logic [6:0]   hc;
  } exp_t;

  exp_t exp_q[$];

  sprite_line_scheduler #(.NUM_ENTRIES(16), .NUM_SLOTS(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .line_start (line_start),
    .next_line  (next_line),
    .slot_val   (slot_val),
    .slot_valid (slot_valid),
    .busy       (busy),
`ifdef SPRITE_SCHED_HIT_COUNT_EN
    .hit_count  (hit_count),
`endif
    .overflow   (overflow)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] desc(input logic [5:0] id,
                                       input logic [9:0] x,
                                       input logic [9:0] y);
    return {id, 2'b00, x, y, 4'b0000};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge Clk);
    #1;
    wr_en = 1'b0;
  endtask

  // act: 0 none, 1 write at cycle, 2 extra line_start at cycle
  task automatic run_line(input string tag, input logic [9:0] ln,
                          input int act, input int cyc,
                          input logic [3:0] a, input logic [31:0] d,
                          input logic [127:0] ev, input logic [3:0] evv,
                          input logic eovf, input logic [6:0] ehc);
    exp_t e;
    exp_t g;
    int n;
    e.val = ev;
    e.v = evv;
    e.ovf = eovf;
    e.hc = ehc;
    exp_q.push_back(e);
    line_start = 1'b1;
    next_line = ln;
    @(posedge Clk);
    #1;
    line_start = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge Clk);
      #1;
      n++;
      wr_en = 1'b0;
      line_start = 1'b0;
      if (act == 2 && n == cyc + 2)
        check({tag, "_busy_held"}, {127'd0, busy}, 128'd1);
      if (busy === 1'b0) break;
      if (n == cyc && act == 1) begin
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
      end
      if (n == cyc && act == 2) begin
        line_start = 1'b1;
        next_line = 10'd1020;
      end
    end
    check({tag, "_latency"}, 128'(n), 128'd17);
    if (exp_q.size() > 0) begin
      g = exp_q.pop_front();
      check({tag, "_slot_val"}, slot_val, g.val);
      check({tag, "_slot_valid"}, {124'd0, slot_valid}, {124'd0, g.v});
      check({tag, "_overflow"}, {127'd0, overflow}, {127'd0, g.ovf});
`ifdef SPRITE_SCHED_HIT_COUNT_EN
      check({tag, "_hit_count"}, {121'd0, hit_count}, {121'd0, g.hc});
`endif
    end
  endtask

  logic [31:0] d0, d1, d3, d5, d7, dh, d12, d2;

  initial begin
    d0  = desc(6'd2, 10'd100, 10'd50);
    d1  = desc(6'd26, 10'd1, 10'd200);
    d3  = desc(6'd26, 10'd3, 10'd200);
    d5  = desc(6'd26, 10'd5, 10'd200);
    d7  = desc(6'd26, 10'd7, 10'd200);
    dh  = desc(6'd26, 10'd9, 10'd1015);
    d12 = desc(6'd2, 10'd12, 10'd205);
    d2  = desc(6'd26, 10'd2, 10'd200);

    repeat (2) @(posedge Clk);
    #1;
    check("rst_slot_val", slot_val, 128'd0);
    check("rst_slot_valid", {124'd0, slot_valid}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_overflow", {127'd0, overflow}, 128'd0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    wr(4'd0, d0);
    run_line("y58", 10'd58, 0, 0, 4'd0, 32'd0,
             {96'd0, d0}, 4'b0001, 1'b0, 7'd1);
    run_line("y59", 10'd59, 0, 0, 4'd0, 32'd0,
             128'd0, 4'b0000, 1'b0, 7'd0);
    run_line("y49", 10'd49, 0, 0, 4'd0, 32'd0,
             128'd0, 4'b0000, 1'b0, 7'd0);
    run_line("y50", 10'd50, 0, 0, 4'd0, 32'd0,
             {96'd0, d0}, 4'b0001, 1'b0, 7'd1);

    line_start = 1'b1;
    next_line = 10'd58;
    @(posedge Clk);
    #1;
    line_start = 1'b0;
    repeat (5) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_slot_val", slot_val, 128'd0);
    check("midrst_slot_valid", {124'd0, slot_valid}, 128'd0);
    check("midrst_busy", {127'd0, busy}, 128'd0);
    check("midrst_overflow", {127'd0, overflow}, 128'd0);
`ifdef SPRITE_SCHED_HIT_COUNT_EN
    check("midrst_hit_count", {121'd0, hit_count}, 128'd0);
`endif
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    run_line("after_rst", 10'd58, 0, 0, 4'd0, 32'd0,
             128'd0, 4'b0000, 1'b0, 7'd0);

    wr(4'd0, d0);
    wr(4'd1, d1);
    wr(4'd3, d3);
    wr(4'd5, d5);
    wr(4'd7, d7);
    wr(4'd9, desc(6'd26, 10'd9, 10'd200));
    run_line("ovf", 10'd210, 0, 0, 4'd0, 32'd0,
             {d7, d5, d3, d1}, 4'b1111, 1'b1, 7'd5);

    wr(4'd0, dh);
    run_line("y1020", 10'd1020, 0, 0, 4'd0, 32'd0,
             {96'd0, dh}, 4'b0001, 1'b0, 7'd1);
    run_line("y5", 10'd5, 0, 0, 4'd0, 32'd0,
             128'd0, 4'b0000, 1'b0, 7'd0);

    run_line("dbl_start", 10'd210, 2, 4, 4'd0, 32'd0,
             {d7, d5, d3, d1}, 4'b1111, 1'b1, 7'd5);

    wr(4'd1, 32'd0);
    wr(4'd3, 32'd0);
    wr(4'd5, 32'd0);
    wr(4'd7, 32'd0);
    wr(4'd9, 32'd0);
    run_line("wr_e12", 10'd210, 1, 3, 4'd12, d12,
             {96'd0, d12}, 4'b0001, 1'b0, 7'd1);
    run_line("wr_e2", 10'd210, 1, 8, 4'd2, d2,
             {96'd0, d12}, 4'b0001, 1'b0, 7'd1);
    run_line("e2_next", 10'd210, 0, 0, 4'd0, 32'd0,
             {64'd0, d12, d2}, 4'b0011, 1'b0, 7'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
